// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory stage of the 32-bit multi-cycle RISC-V core. Executes LB/LH/LW/LBU/LHU
// and SB/SH/SW over a valid/ready memory port. Non-memory instructions forward
// their ALU result. Produces a one-cycle lsu_finish strobe with the write-back
// value (wdata) and an error flag (lsu_err).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             instruction valid from EXU (sampled only in IDLE)
//   is_load/is_store  instruction class (both set -> store)
//   funct3            access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr              effective byte address
//   store_data        rs2 value for stores
//   alu_result        result forwarded for non-memory instructions
//   mem_req_*         request channel (valid/ready, word address, wen, wdata, wstrb)
//   mem_resp_*        response channel (valid, rdata, err)
//   lsu_finish        one-cycle completion pulse
//   wdata             write-back value, held until the next completion
//   lsu_err           misaligned / invalid access, bus error or timeout
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp_err,
  output logic                  lsu_finish,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  lsu_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last WAIT cycle index; the access aborts after TIMEOUT_CYCLES cycles in WAIT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Misaligned or unsupported access size for a memory instruction.
  function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010:         bad = (off != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte strobes for a store of the given size at byte offset off.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] strb;
    case (f3[1:0])
      2'b00:   strb = 4'b0001 << off;
      2'b01:   strb = 4'b0011 << off;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Store data replicated so the strobed lanes carry the right bytes.
  function automatic logic [31:0] store_lane(input logic [31:0] sd, input logic [2:0] f3);
    logic [31:0] lane;
    case (f3[1:0])
      2'b00:   lane = {4{sd[7:0]}};
      2'b01:   lane = {2{sd[15:0]}};
      default: lane = sd;
    endcase
    return lane;
  endfunction

  // Select and extend the addressed byte/half from a full read word.
  function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    if (off[1]) begin
      h = rd[31:16];
    end else begin
      h = rd[15:0];
    end
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h00_0000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  state_t                 state_r;
  state_t                 next_state_s;
  logic [ADDR_WIDTH-1:0]  addr_r;
  logic [2:0]             funct3_r;
  logic                   load_r;
  logic                   store_r;
  logic [3:0]             wstrb_r;
  logic [DATA_WIDTH-1:0]  lane_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [DATA_WIDTH-1:0]  wdata_r;
  logic                   err_r;
  logic                   mem_req_valid_s;
  logic                   lsu_finish_s;
  logic                   start_mem_s;
  logic                   start_bad_s;

  assign start_mem_s = is_load | is_store;
  assign start_bad_s = access_bad(funct3, addr[1:0]);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (!start_mem_s || start_bad_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = REQ;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          next_state_s = WAIT;
        end else begin
          next_state_s = REQ;
        end
      end
      WAIT: begin
        if (mem_resp_valid || (cnt_r == CNT_LAST)) begin
          next_state_s = DONE;
        end else begin
          next_state_s = WAIT;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output decode (from the state register only, so glitch-free).
  always_comb begin
    mem_req_valid_s = 1'b0;
    lsu_finish_s    = 1'b0;
    case (state_r)
      REQ:     mem_req_valid_s = 1'b1;
      DONE:    lsu_finish_s    = 1'b1;
      default: begin
        mem_req_valid_s = 1'b0;
        lsu_finish_s    = 1'b0;
      end
    endcase
  end

  // Request capture, WAIT timeout counter and write-back result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r   <= '0;
      funct3_r <= 3'b000;
      load_r   <= 1'b0;
      store_r  <= 1'b0;
      wstrb_r  <= 4'b0000;
      lane_r   <= '0;
      cnt_r    <= '0;
      wdata_r  <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            addr_r   <= addr;
            funct3_r <= funct3;
            store_r  <= is_store;
            load_r   <= is_load & ~is_store;  // store wins when both are set
            cnt_r    <= '0;
            if (is_store) begin
              wstrb_r <= store_strb(funct3, addr[1:0]);
              lane_r  <= store_lane(store_data, funct3);
            end else begin
              wstrb_r <= 4'b0000;
              lane_r  <= '0;
            end
            // Results that complete without a bus access are known right now.
            if (!start_mem_s) begin
              wdata_r <= alu_result;
              err_r   <= 1'b0;
            end else if (start_bad_s) begin
              wdata_r <= '0;
              err_r   <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            err_r <= mem_resp_err;
            if (load_r && !mem_resp_err) begin
              wdata_r <= load_extract(mem_rdata, funct3_r, addr_r[1:0]);
            end else begin
              wdata_r <= '0;
            end
          end else if (cnt_r == CNT_LAST) begin
            err_r   <= 1'b1;
            wdata_r <= '0;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign mem_req_valid = mem_req_valid_s;
  assign lsu_finish    = lsu_finish_s;
  assign mem_addr      = {addr_r[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wen       = store_r;
  assign mem_wdata     = lane_r;
  assign mem_wstrb     = wstrb_r;
  assign wdata         = wdata_r;
  assign lsu_err       = err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit: pass-through, load extension, store lane
// steering, backpressure, misalignment, bus error, timeout and async reset.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] alu_result;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;
  logic        lsu_finish;
  logic [31:0] wdata;
  logic        lsu_err;

  int n_assert;
  int n_fail;

  load_store_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .is_load(is_load),
    .is_store(is_store),
    .funct3(funct3),
    .addr(addr),
    .store_data(store_data),
    .alu_result(alu_result),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr),
    .mem_wen(mem_wen),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata),
    .mem_resp_err(mem_resp_err),
    .lsu_finish(lsu_finish),
    .wdata(wdata),
    .lsu_err(lsu_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected end before 200000");
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    start    = 1'b1;
    is_load  = ld;
    is_store = st;
    funct3   = f3;
    addr     = a;
    store_data = sd;
    tick();
    start    = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
  endtask

  initial begin
    int k;
    int pulses;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; alu_result = 32'h0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = 32'h0; mem_resp_err = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_finish",    {31'd0, lsu_finish},    32'd0);
    chk("rst_err",       {31'd0, lsu_err},       32'd0);
    chk("rst_wdata",     wdata,                  32'd0);
    chk("rst_wstrb",     {28'd0, mem_wstrb},     32'd0);
    chk("rst_wen",       {31'd0, mem_wen},       32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Non-memory pass-through: finish on the next cycle
    alu_result = 32'h1234_5678;
    issue(1'b0, 1'b0, 3'b000, 32'h0000_0000, 32'h0);
    chk("alu_finish", {31'd0, lsu_finish}, 32'd1);
    chk("alu_wdata",  wdata, 32'h1234_5678);
    chk("alu_err",    {31'd0, lsu_err}, 32'd0);
    chk("alu_noreq",  {31'd0, mem_req_valid}, 32'd0);
    tick();
    chk("alu_pulse_end", {31'd0, lsu_finish}, 32'd0);
    chk("alu_hold",      wdata, 32'h1234_5678);
    chk("alu_noreq2",    {31'd0, mem_req_valid}, 32'd0);

    // LB sign extension, ready and response immediate (resp held high is ignored outside WAIT)
    mem_rdata = 32'h80FF_0000;
    mem_resp_valid = 1'b1;
    issue(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0);
    chk("lb_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("lb_addr",      mem_addr, 32'h8000_0000);
    chk("lb_wen",       {31'd0, mem_wen}, 32'd0);
    chk("lb_wstrb",     {28'd0, mem_wstrb}, 32'd0);
    tick();
    chk("lb_wait_nofin", {31'd0, lsu_finish}, 32'd0);
    chk("lb_wait_valid", {31'd0, mem_req_valid}, 32'd0);
    tick();
    chk("lb_finish", {31'd0, lsu_finish}, 32'd1);
    chk("lb_wdata",  wdata, 32'hFFFF_FF80);
    chk("lb_err",    {31'd0, lsu_err}, 32'd0);
    tick();

    // LBU zero extension
    issue(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0);
    chk("lbu_addr", mem_addr, 32'h8000_0000);
    tick();
    tick();
    chk("lbu_finish", {31'd0, lsu_finish}, 32'd1);
    chk("lbu_wdata",  wdata, 32'h0000_0080);
    tick();

    // LW aligned
    mem_rdata = 32'hCAFE_F00D;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0);
    tick();
    tick();
    chk("lw_finish", {31'd0, lsu_finish}, 32'd1);
    chk("lw_wdata",  wdata, 32'hCAFE_F00D);
    tick();

    // LH upper half, sign extension; then LHU
    mem_rdata = 32'h8001_0000;
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0302, 32'h0);
    tick();
    tick();
    chk("lh_wdata", wdata, 32'hFFFF_8001);
    tick();
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0302, 32'h0);
    tick();
    tick();
    chk("lhu_wdata", wdata, 32'h0000_8001);
    tick();

    // Load and store both set -> SB at offset 1
    issue(1'b1, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_0055);
    chk("sb_wen",   {31'd0, mem_wen}, 32'd1);
    chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h2);
    chk("sb_wdata", mem_wdata, 32'h5555_5555);
    tick();
    tick();
    chk("sb_finish", {31'd0, lsu_finish}, 32'd1);
    chk("sb_wdata_wb", wdata, 32'd0);
    tick();

    // SH at offset 2 with 5 cycles of backpressure, response 3 cycles after handshake
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    alu_result = 32'h0BAD_0BAD;
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'hAAAA_BEEF);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("bp_addr",  mem_addr, 32'h0000_0010);
      chk("bp_wdata", mem_wdata, 32'hBEEF_BEEF);
      chk("bp_wstrb", {28'd0, mem_wstrb}, 32'hC);
      chk("bp_wen",   {31'd0, mem_wen}, 32'd1);
      start = 1'b1;      // start while busy is ignored
      tick();
      start = 1'b0;
    end
    chk("bp_valid_last", {31'd0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    tick();
    chk("bp_valid_drop", {31'd0, mem_req_valid}, 32'd0);
    chk("bp_wait1", {31'd0, lsu_finish}, 32'd0);
    tick();
    chk("bp_wait2", {31'd0, lsu_finish}, 32'd0);
    tick();
    mem_rdata = 32'hDEAD_BEEF;
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    chk("sh_finish", {31'd0, lsu_finish}, 32'd1);
    chk("sh_wdata",  wdata, 32'd0);
    chk("sh_err",    {31'd0, lsu_err}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (lsu_finish) pulses++;
    end
    chk("sh_single_pulse", pulses, 32'd0);

    // Misaligned LW: finish next cycle with error, no request
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0);
    chk("mis_finish", {31'd0, lsu_finish}, 32'd1);
    chk("mis_err",    {31'd0, lsu_err}, 32'd1);
    chk("mis_wdata",  wdata, 32'd0);
    chk("mis_noreq",  {31'd0, mem_req_valid}, 32'd0);
    tick();
    chk("mis_noreq2", {31'd0, mem_req_valid}, 32'd0);

    // Invalid funct3 load -> error
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0);
    chk("inv_finish", {31'd0, lsu_finish}, 32'd1);
    chk("inv_err",    {31'd0, lsu_err}, 32'd1);
    tick();

    // Good LH to make wdata nonzero, then bus error response
    mem_rdata = 32'h0000_1234;
    mem_resp_valid = 1'b1;
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0200, 32'h0);
    tick();
    tick();
    chk("pre_err_wdata", wdata, 32'h0000_1234);
    chk("pre_err_err",   {31'd0, lsu_err}, 32'd0);
    tick();
    mem_resp_err = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
    tick();
    tick();
    chk("berr_finish", {31'd0, lsu_finish}, 32'd1);
    chk("berr_err",    {31'd0, lsu_err}, 32'd1);
    chk("berr_wdata",  wdata, 32'd0);
    mem_resp_err = 1'b0;
    mem_resp_valid = 1'b0;
    tick();

    // Timeout: 255 cycles in WAIT without response
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
    tick();
    k = 0;
    while (!lsu_finish && k < 400) begin
      tick();
      k++;
    end
    chk("to_latency", k, 32'd255);
    chk("to_err",     {31'd0, lsu_err}, 32'd1);
    chk("to_wdata",   wdata, 32'd0);
    tick();
    mem_rdata = 32'h1111_1111;
    mem_resp_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (lsu_finish) pulses++;
    end
    mem_resp_valid = 1'b0;
    chk("late_resp_nofin", pulses, 32'd0);

    // Async reset in REQ under backpressure
    mem_req_ready = 1'b0;
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0600, 32'hCAFE_BABE);
    chk("rr_valid", {31'd0, mem_req_valid}, 32'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rr_valid_drop", {31'd0, mem_req_valid}, 32'd0);
    chk("rr_nofin",      {31'd0, lsu_finish}, 32'd0);
    tick();
    rst = 1'b0;
    mem_req_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (lsu_finish || mem_req_valid) pulses++;
    end
    chk("rr_idle_after", pulses, 32'd0);

    // Next access after reset completes normally (LBU at offset 3)
    mem_rdata = 32'h7F00_0000;
    mem_resp_valid = 1'b1;
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0703, 32'h0);
    chk("post_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("post_addr",  mem_addr, 32'h0000_0700);
    tick();
    tick();
    chk("post_finish", {31'd0, lsu_finish}, 32'd1);
    chk("post_wdata",  wdata, 32'h0000_007F);
    chk("post_err",    {31'd0, lsu_err}, 32'd0);
    mem_resp_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
